move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
Turn controller for the 4x4 Connect-4 board. Accepts the column switches and the drop button, and validates each move against per-column fill heights. It writes the occupancy board and the player-ownership board, then hands the new board to the winner detector and waits for its verdict. Finally it either passes the turn or ends the game. It is the single owner and writer of gameboard/player_cells, which feed the LED column drivers and the winner detector.

Parameters:
SYNC_STAGES, 2, flop stages on drop_btn before edge detect (min 2)
CHECK_TIMEOUT, 15, cycles to wait for check_done before forcing "no winner"
FIRST_PLAYER, 0, player who moves first after reset/new_game

Ports:
clk  in  1  system clock (the divided game clock)
reset  in  1  asynchronous, active-high; clears all state
col_sel  in  4  column switches {Switch_3..Switch_0}; must be one-hot
drop_btn  in  1  raw drop button (BTN_EAST), asynchronous level
new_game  in  1  synchronous level; honoured only in GAME_OVER
check_done  in  1  winner detector verdict valid, one-cycle pulse
check_result  in  2  00 none, 01 player0 wins, 10 player1 wins, 11 treated as none
gameboard  out  16  occupancy; bit = col*4 + row, row 0 = bottom
player_cells  out  16  owner of occupied cell (0 = player0, 1 = player1); 0 where unoccupied
current_player  out  1  player whose turn it is
state  out  2  00 IDLE, 01 PLACE, 10 CHECK, 11 GAME_OVER
game_status  out  2  00 playing, 01 p0 win, 10 p1 win, 11 draw
check_req  out  1  one-cycle pulse: board updated, evaluate
move_reject  out  1  one-cycle pulse: drop refused
check_timeout  out  1  sticky until new_game/reset: a check timed out

Behaviour:
- Reset (async, active-high): gameboard=0, player_cells=0, all heights=0, move_count=0, current_player=FIRST_PLAYER, state=IDLE, game_status=00, check_req=0, move_reject=0, check_timeout=0, sync chain=0.
- drop_btn goes through SYNC_STAGES flops, then a rising-edge detector producing drop_evt (one cycle). A held button produces exactly one event.
- IDLE, drop_evt:
  - col_sel not exactly one-hot: move_reject pulses next cycle; stay in IDLE.
  - Selected column height == 4: move_reject pulses; stay in IDLE.
  - Otherwise: latch column index c, go to PLACE.
  - drop_evt in any other state is discarded (no reject pulse).
- PLACE (exactly 1 cycle):
  - Set gameboard[c*4+h[c]] = 1 and player_cells[same bit] = current_player.
  - h[c] += 1 (3-bit, saturates at 4); move_count += 1 (5-bit, 0..16).
  - Next state CHECK; check_req is high during the first CHECK cycle only.
- CHECK: wait for check_done. check_done coincident with the check_req cycle is accepted.
  - result 01/10: game_status = result, go to GAME_OVER.
  - Else, move_count == 16: game_status = 11, go to GAME_OVER.
  - Else: toggle current_player, go to IDLE.
  - If CHECK_TIMEOUT cycles pass with no check_done: set check_timeout, then proceed as result 00.
  - check_done outside CHECK is ignored.
- Latency: drop_evt to board bit visible = 2 cycles (IDLE to PLACE, PLACE registers).
- GAME_OVER: board, player and status are frozen; drops are ignored.
  - new_game=1: synchronously clear board, heights, move_count, check_timeout, game_status; current_player=FIRST_PLAYER; go to IDLE next cycle.
  - new_game is ignored in every other state.
- Reset asserted mid-PLACE or mid-CHECK aborts the move immediately; no partial board survives.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then drop with col_sel=0001 -> after 2 cycles gameboard=0x0001, player_cells=0x0000. check_req pulses once. Respond done/00 -> current_player=1, state=IDLE.
- Four alternating drops into column 2 (col_sel=0100), checker answering 00 -> gameboard=0x0F00, player_cells=0x0A00. Fifth drop -> move_reject pulse, board unchanged.
- col_sel=0011 or 0000 with drop -> move_reject pulses, state stays 00, no check_req.
- Player0 drops in column 0 and player1 in column 1, three times each; player0's 4th drop in column 0, checker returns 01 -> game_status=01, state=11. A further drop is ignored. new_game -> board 0, player 0, state IDLE.
- Fill all 16 cells with checker always 00 -> after the 16th check game_status=11, state=GAME_OVER.
- Hold check_done low after check_req -> check_timeout=1 after 15 cycles, turn passes. Separately, assert reset during CHECK -> all outputs return to reset values at once. Hold drop_btn high for 100 cycles -> exactly one placement.

Source files
------------

// File: rtl/move_sequencer_if.sv
// Handshake bundle between the Connect-4 turn controller and its environment
// (switches, button, winner detector, LED drivers).
interface move_sequencer_if;
    logic [3:0]  col_sel;
    logic        drop_btn;
    logic        new_game;
    logic        check_done;
    logic [1:0]  check_result;
    logic [15:0] gameboard;
    logic [15:0] player_cells;
    logic        current_player;
    logic [1:0]  state;
    logic [1:0]  game_status;
    logic        check_req;
    logic        move_reject;
    logic        check_timeout;

    modport master (
        output col_sel, drop_btn, new_game, check_done, check_result,
        input  gameboard, player_cells, current_player, state, game_status,
               check_req, move_reject, check_timeout
    );

    modport slave (
        input  col_sel, drop_btn, new_game, check_done, check_result,
        output gameboard, player_cells, current_player, state, game_status,
               check_req, move_reject, check_timeout
    );
endinterface

// File: rtl/move_sequencer.sv
// Connect-4 (4x4) turn controller: validates drops, owns the occupancy and
// ownership boards, requests a winner check and passes the turn or ends the game.
module move_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int CHECK_TIMEOUT = 15,
    parameter bit FIRST_PLAYER  = 1'b0
) (
    input logic             clk,
    input logic             reset,
    move_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PLACE     = 2'b01,
        CHECK     = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TMO_W  = $clog2(CHECK_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [SYNC_N-1:0] sync_q;
    logic              btn_prev;
    logic              drop_evt;
    logic [1:0]        col_q;
    logic [1:0]        col_idx;
    logic              col_valid;
    logic              drop_ok;
    logic [2:0]        height [4];
    logic [4:0]        move_count;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              timed_out, winner, resolve;
    logic [15:0]       board_q, owner_q;
    logic              player_q, req_q, reject_q, tmo_flag_q;
    logic [1:0]        status_q;

    function automatic logic [2:0] sat_inc(input logic [2:0] h);
        return (h == 3'd4) ? h : h + 3'd1;
    endfunction

    assign drop_evt = sync_q[SYNC_N-1] & ~btn_prev;

    always_comb begin
        col_valid = 1'b1;
        col_idx   = 2'd0;
        case (bus.col_sel)
            4'b0001: col_idx = 2'd0;
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_valid = 1'b0;
        endcase
    end

    assign drop_ok   = drop_evt && col_valid && (height[col_idx] != 3'd4);
    assign timed_out = !bus.check_done && (tmo_cnt == TMO_W'(CHECK_TIMEOUT - 1));
    assign winner    = bus.check_done && (bus.check_result == 2'b01 || bus.check_result == 2'b10);
    assign resolve   = bus.check_done || timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (drop_ok) state_d = PLACE;
            PLACE:     state_d = CHECK;
            CHECK: begin
                if (winner)                        state_d = GAME_OVER;
                else if (resolve && move_count == 5'd16) state_d = GAME_OVER;
                else if (resolve)                  state_d = IDLE;
            end
            GAME_OVER: if (bus.new_game) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            btn_prev   <= 1'b0;
            col_q      <= 2'd0;
            for (int i = 0; i < 4; i++) height[i] <= 3'd0;
            move_count <= 5'd0;
            tmo_cnt    <= '0;
            board_q    <= 16'h0000;
            owner_q    <= 16'h0000;
            player_q   <= FIRST_PLAYER;
            status_q   <= 2'b00;
            req_q      <= 1'b0;
            reject_q   <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_N-2:0], bus.drop_btn};
            btn_prev <= sync_q[SYNC_N-1];
            reject_q <= (state_q == IDLE) && drop_evt && !drop_ok;
            req_q    <= (state_q == PLACE);
            case (state_q)
                IDLE: if (drop_ok) col_q <= col_idx;
                PLACE: begin
                    // Height is below 4 here, so the low two bits address the row.
                    board_q[{col_q, height[col_q][1:0]}] <= 1'b1;
                    owner_q[{col_q, height[col_q][1:0]}] <= player_q;
                    height[col_q] <= sat_inc(height[col_q]);
                    move_count    <= move_count + 5'd1;
                    tmo_cnt       <= '0;
                end
                CHECK: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (winner) begin
                        status_q <= bus.check_result;
                    end else if (resolve) begin
                        if (timed_out) tmo_flag_q <= 1'b1;
                        if (move_count == 5'd16) status_q <= 2'b11;
                        else                     player_q <= ~player_q;
                    end
                end
                GAME_OVER: if (bus.new_game) begin
                    board_q    <= 16'h0000;
                    owner_q    <= 16'h0000;
                    for (int i = 0; i < 4; i++) height[i] <= 3'd0;
                    move_count <= 5'd0;
                    tmo_flag_q <= 1'b0;
                    status_q   <= 2'b00;
                    player_q   <= FIRST_PLAYER;
                end
                default: ;
            endcase
        end
    end

    assign bus.gameboard      = board_q;
    assign bus.player_cells   = owner_q;
    assign bus.current_player = player_q;
    assign bus.state          = state_q;
    assign bus.game_status    = status_q;
    assign bus.check_req      = req_q;
    assign bus.move_reject    = reject_q;
    assign bus.check_timeout  = tmo_flag_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: vector table of drops plus hand-written
// sequences for latency, win, draw, timeout, async reset and button hold.
module tb_move_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    move_sequencer_if bus ();

    move_sequencer #(
        .SYNC_STAGES  (2),
        .CHECK_TIMEOUT(15),
        .FIRST_PLAYER (1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  col;
        logic [1:0]  res;
        logic [15:0] board;
        logic [15:0] cells;
        logic        player;
        logic [1:0]  st;
        logic [1:0]  gs;
        logic        rej;
        logic        req;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.col_sel      = 4'b0000;
        bus.drop_btn     = 1'b0;
        bus.new_game     = 1'b0;
        bus.check_done   = 1'b0;
        bus.check_result = 2'b00;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One button press; answers the first check_req with res.
    task automatic run_drop(input logic [3:0] col, input logic [1:0] res,
                            output logic rej, output logic req);
        rej = 1'b0;
        req = 1'b0;
        bus.col_sel  = col;
        bus.drop_btn = 1'b1;
        for (int i = 0; i < 8 && !req; i++) begin
            tick();
            if (bus.move_reject) rej = 1'b1;
            if (bus.check_req)   req = 1'b1;
        end
        if (req) begin
            bus.check_done   = 1'b1;
            bus.check_result = res;
            tick();
            bus.check_done   = 1'b0;
            bus.check_result = 2'b00;
        end
        bus.drop_btn = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic rej, req;
        int   nreq;

        vecs[0] = '{4'b0011, 2'b00, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[1] = '{4'b0000, 2'b00, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[2] = '{4'b0100, 2'b00, 16'h0100, 16'h0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[3] = '{4'b0100, 2'b00, 16'h0300, 16'h0200, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[4] = '{4'b0100, 2'b11, 16'h0700, 16'h0200, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[5] = '{4'b0100, 2'b00, 16'h0F00, 16'h0A00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[6] = '{4'b0100, 2'b00, 16'h0F00, 16'h0A00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[7] = '{4'b0001, 2'b00, 16'h0F01, 16'h0A00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[8] = '{4'b0001, 2'b00, 16'h0F03, 16'h0A02, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};

        // Reset values
        do_reset();
        chk("rst_board",  bus.gameboard, 16'h0000);
        chk("rst_cells",  bus.player_cells, 16'h0000);
        chk("rst_player", 16'(bus.current_player), 16'h0);
        chk("rst_state",  16'(bus.state), 16'h0);
        chk("rst_status", 16'(bus.game_status), 16'h0);
        chk("rst_flags",  16'({bus.check_req, bus.move_reject, bus.check_timeout}), 16'h0);

        // Exact latency of the first placement
        bus.col_sel  = 4'b0001;
        bus.drop_btn = 1'b1;
        repeat (3) tick();
        chk("lat_place_state", 16'(bus.state), 16'h1);
        chk("lat_place_board", bus.gameboard, 16'h0000);
        tick();
        chk("lat_board", bus.gameboard, 16'h0001);
        chk("lat_cells", bus.player_cells, 16'h0000);
        chk("lat_req",   16'(bus.check_req), 16'h1);
        tick();
        chk("req_one_pulse", 16'(bus.check_req), 16'h0);
        chk("still_check",   16'(bus.state), 16'h2);
        bus.check_done = 1'b1;
        tick();
        bus.check_done = 1'b0;
        chk("turn_player", 16'(bus.current_player), 16'h1);
        chk("turn_state",  16'(bus.state), 16'h0);
        bus.drop_btn = 1'b0;
        repeat (4) tick();

        // Vector table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_drop(vecs[i].col, vecs[i].res, rej, req);
            chk($sformatf("v%0d_board", i),  bus.gameboard, vecs[i].board);
            chk($sformatf("v%0d_cells", i),  bus.player_cells, vecs[i].cells);
            chk($sformatf("v%0d_player", i), 16'(bus.current_player), 16'(vecs[i].player));
            chk($sformatf("v%0d_state", i),  16'(bus.state), 16'(vecs[i].st));
            chk($sformatf("v%0d_status", i), 16'(bus.game_status), 16'(vecs[i].gs));
            chk($sformatf("v%0d_reject", i), 16'(rej), 16'(vecs[i].rej));
            chk($sformatf("v%0d_req", i),    16'(req), 16'(vecs[i].req));
        end

        // Player 0 wins vertically in column 0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_drop(4'b0001, 2'b00, rej, req);
            run_drop(4'b0010, 2'b00, rej, req);
        end
        run_drop(4'b0001, 2'b01, rej, req);
        chk("win_status", 16'(bus.game_status), 16'h1);
        chk("win_state",  16'(bus.state), 16'h3);
        chk("win_board",  bus.gameboard, 16'h007F);
        chk("win_cells",  bus.player_cells, 16'h0070);
        run_drop(4'b1000, 2'b00, rej, req);
        chk("go_drop_ignored", bus.gameboard, 16'h007F);
        chk("go_no_events",    16'({rej, req}), 16'h0);
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        chk("ng_board",  bus.gameboard, 16'h0000);
        chk("ng_cells",  bus.player_cells, 16'h0000);
        chk("ng_player", 16'(bus.current_player), 16'h0);
        chk("ng_state",  16'(bus.state), 16'h0);
        chk("ng_status", 16'(bus.game_status), 16'h0);

        // Full board with no winner is a draw
        do_reset();
        nreq = 0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                run_drop(4'(1 << c), 2'b00, rej, req);
                if (req) nreq++;
            end
        end
        chk("draw_reqs",   16'(nreq), 16'd16);
        chk("draw_board",  bus.gameboard, 16'hFFFF);
        chk("draw_cells",  bus.player_cells, 16'hAAAA);
        chk("draw_status", 16'(bus.game_status), 16'h3);
        chk("draw_state",  16'(bus.state), 16'h3);
        chk("draw_player", 16'(bus.current_player), 16'h1);

        // Checker never answers
        do_reset();
        bus.col_sel  = 4'b0001;
        bus.drop_btn = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 10 && !req; i++) begin
            tick();
            req = bus.check_req;
        end
        chk("tmo_req_seen", 16'(req), 16'h1);
        repeat (14) tick();
        chk("tmo_early_state", 16'(bus.state), 16'h2);
        chk("tmo_early_flag",  16'(bus.check_timeout), 16'h0);
        tick();
        chk("tmo_state",  16'(bus.state), 16'h0);
        chk("tmo_flag",   16'(bus.check_timeout), 16'h1);
        chk("tmo_player", 16'(bus.current_player), 16'h1);
        bus.drop_btn = 1'b0;
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        chk("tmo_sticky", 16'(bus.check_timeout), 16'h1);

        // Asynchronous reset in the middle of CHECK
        do_reset();
        bus.col_sel  = 4'b0100;
        bus.drop_btn = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 10 && !req; i++) begin
            tick();
            req = bus.check_req;
        end
        bus.drop_btn = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_board", bus.gameboard, 16'h0000);
        chk("arst_state", 16'(bus.state), 16'h0);
        chk("arst_req",   16'(bus.check_req), 16'h0);
        tick();
        reset = 1'b0;
        tick();

        // Button held for 100 cycles gives one placement
        do_reset();
        bus.col_sel  = 4'b0001;
        bus.drop_btn = 1'b1;
        nreq = 0;
        for (int i = 0; i < 100; i++) begin
            bus.check_done = bus.check_req;
            tick();
            if (bus.check_req) nreq++;
        end
        bus.check_done = 1'b0;
        bus.drop_btn   = 1'b0;
        chk("hold_reqs",  16'(nreq), 16'd1);
        chk("hold_board", bus.gameboard, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
